// File: rtl/ring_port_arbiter.sv
// ring_port_arbiter: wormhole output-port arbiter sharing one outbound ring
// link between upstream through-traffic and local injection. A source wins
// at a packet boundary and keeps the link for all FLITS flits of its packet.
// Optional feature macro: RING_ARB_STARVE_EN enables the anti-starvation
// counter that forces a local grant after STARVE_MAX contested ring packets;
// without it ring has strict priority.
module ring_port_arbiter #(
    parameter int unsigned FLIT_W     = 64,
    parameter int unsigned FLITS      = 9,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              ring_valid,
    input  logic [FLIT_W-1:0] ring_flit,
    output logic              ring_ready,
    input  logic              local_valid,
    input  logic [FLIT_W-1:0] local_flit,
    output logic              local_ready,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    input  logic              out_ready,
    output logic              out_head,
    output logic              grant_ring,
    output logic              grant_local,
    output logic              pkt_done
);

    localparam int unsigned FCNT_W = (FLITS > 2) ? $clog2(FLITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RING  = 2'd1,
        LOCAL = 2'd2
    } state_t;

    state_t              state;
    logic [FCNT_W-1:0]   fcnt;
    logic                arb_open;
    logic                local_pri;
    logic                pick_ring;
    logic                pick_local;
    logic                xfer;
    logic                last_flit;

`ifdef RING_ARB_STARVE_EN
    localparam int unsigned SCNT_W = $clog2(STARVE_MAX + 1);
    logic [SCNT_W-1:0]   scnt;
    assign local_pri = (scnt == SCNT_W'(STARVE_MAX));
`else
    assign local_pri = 1'b0;
`endif

    // Arbitration is open between packets; reset forces the packet-boundary view.
    assign arb_open  = !rst_l || (state == IDLE);
    assign last_flit = (state != IDLE) && (fcnt == FCNT_W'(FLITS - 1));

    // Grant selection and combinational datapath to the outbound link.
    always_comb begin
        pick_ring   = ring_valid && !(local_valid && local_pri);
        pick_local  = local_valid && !pick_ring;
        grant_ring  = arb_open ? pick_ring  : (state == RING);
        grant_local = arb_open ? pick_local : (state == LOCAL);
        out_valid   = (grant_ring && ring_valid) || (grant_local && local_valid);
        out_flit    = grant_local ? local_flit : ring_flit;
        ring_ready  = grant_ring && out_ready;
        local_ready = grant_local && out_ready;
        xfer        = out_valid && out_ready;
        out_head    = arb_open;
        pkt_done    = rst_l && xfer && last_flit;
    end

    // Packet ownership FSM, flit position counter and starvation counter.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state <= IDLE;
            fcnt  <= '0;
`ifdef RING_ARB_STARVE_EN
            scnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        fcnt  <= FCNT_W'(1);
                        state <= grant_ring ? RING : LOCAL;
                    end
                end
                RING, LOCAL: begin
                    if (xfer) begin
                        if (last_flit) begin
                            fcnt  <= '0;
                            state <= IDLE;
                        end else begin
                            fcnt  <= fcnt + FCNT_W'(1);
                        end
                    end
                end
                default: begin
                    fcnt  <= '0;
                    state <= IDLE;
                end
            endcase
`ifdef RING_ARB_STARVE_EN
            if ((state == IDLE) && xfer) begin
                if (grant_local) begin
                    scnt <= '0;
                end else if (local_valid && !local_pri) begin
                    scnt <= scnt + SCNT_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ring_port_arbiter.sv
// tb_ring_port_arbiter: directed scenarios plus randomized traffic checked
// against a packet-level reference model of the ring output-port arbiter.
module tb_ring_port_arbiter;

    localparam int unsigned FLIT_W     = 64;
    localparam int unsigned FLITS      = 9;
    localparam int unsigned STARVE_MAX = 4;
`ifdef RING_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_l;
    logic              ring_valid;
    logic [FLIT_W-1:0] ring_flit;
    logic              ring_ready;
    logic              local_valid;
    logic [FLIT_W-1:0] local_flit;
    logic              local_ready;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic              out_ready;
    logic              out_head;
    logic              grant_ring;
    logic              grant_local;
    logic              pkt_done;

    ring_port_arbiter #(
        .FLIT_W     (FLIT_W),
        .FLITS      (FLITS),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .ring_valid  (ring_valid),
        .ring_flit   (ring_flit),
        .ring_ready  (ring_ready),
        .local_valid (local_valid),
        .local_flit  (local_flit),
        .local_ready (local_ready),
        .out_valid   (out_valid),
        .out_flit    (out_flit),
        .out_ready   (out_ready),
        .out_head    (out_head),
        .grant_ring  (grant_ring),
        .grant_local (grant_local),
        .pkt_done    (pkt_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Source sequence numbers: each source advances only when its flit is taken.
    int ring_seq  = 0;
    int local_seq = 0;

    // Packet-level model: who holds the link and how many flits remain.
    int m_owner  = 0;   // 0 none, 1 ring, 2 local
    int m_left   = 0;   // flits still owed by the current packet (0 = between packets)
    int m_starve = 0;   // contested ring packets since local last won

    int              e_win;
    logic            e_gr, e_gl, e_valid, e_rr, e_lr, e_head, e_done, e_xfer;
    logic [FLIT_W-1:0] e_flit;

    function automatic logic [FLIT_W-1:0] rflit(input int s);
        return {32'h5249_4e47, 32'(s)};
    endfunction

    function automatic logic [FLIT_W-1:0] lflit(input int s);
        return {32'h4c4f_4341, 32'(s)};
    endfunction

    // Apply inputs for this cycle and derive the expected outputs from the model.
    task automatic drive(input logic rst, input logic rv, input logic lv, input logic ordy);
        rst_l       = rst;
        ring_valid  = rv;
        local_valid = lv;
        out_ready   = ordy;
        ring_flit   = rflit(ring_seq);
        local_flit  = lflit(local_seq);
        if (!rst || m_left == 0) begin
            if (rv && lv) e_win = (STARVE_ON && m_starve >= int'(STARVE_MAX)) ? 2 : 1;
            else if (rv)  e_win = 1;
            else if (lv)  e_win = 2;
            else          e_win = 0;
            e_head = 1'b1;
        end else begin
            e_win  = m_owner;
            e_head = 1'b0;
        end
        e_gr    = (e_win == 1);
        e_gl    = (e_win == 2);
        e_valid = (e_gr && rv) || (e_gl && lv);
        e_flit  = e_gl ? lflit(local_seq) : rflit(ring_seq);
        e_rr    = e_gr && ordy;
        e_lr    = e_gl && ordy;
        e_xfer  = e_valid && ordy;
        e_done  = rst && (m_left == 1) && e_xfer;
        #1;
    endtask

    // Commit the model for this cycle and advance to the next drive point.
    task automatic tick();
        logic racc, lacc;
        racc = ring_valid && ring_ready;
        lacc = local_valid && local_ready;
        if (!rst_l) begin
            m_owner = 0; m_left = 0; m_starve = 0;
        end else if (e_xfer) begin
            if (m_left == 0) begin
                m_owner = e_win;
                m_left  = FLITS - 1;
                if (e_win == 2) m_starve = 0;
                else if (local_valid && m_starve < int'(STARVE_MAX)) m_starve++;
            end else begin
                m_left--;
                if (m_left == 0) m_owner = 0;
            end
        end
        @(posedge clk);
        if (racc) ring_seq++;
        if (lacc) local_seq++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if ({grant_ring, grant_local} !== 2'b10) $display("FAIL reset_grant got=%b exp=10", {grant_ring, grant_local}); else passes++;
        checks++; if ({out_head, pkt_done} !== 2'b10) $display("FAIL reset_head_done got=%b exp=10", {out_head, pkt_done}); else passes++;
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if ({out_valid, grant_ring, grant_local, out_head} !== 4'b0001) $display("FAIL reset_idle got=%b exp=0001", {out_valid, grant_ring, grant_local, out_head}); else passes++;
        tick();
    endtask

    task automatic test_single_local();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            checks++; if ({grant_local, local_ready, ring_ready} !== 3'b110) $display("FAIL single_grant c%0d got=%b exp=110", i, {grant_local, local_ready, ring_ready}); else passes++;
            checks++; if ({out_head, pkt_done} !== {i == 0, i == 8}) $display("FAIL single_head_done c%0d got=%b exp=%b", i, {out_head, pkt_done}, {i == 0, i == 8}); else passes++;
            checks++; if (out_flit !== lflit(local_seq)) $display("FAIL single_flit c%0d got=%h exp=%h", i, out_flit, lflit(local_seq)); else passes++;
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if ({out_head, grant_local} !== 2'b10) $display("FAIL single_idle got=%b exp=10", {out_head, grant_local}); else passes++;
        tick();
    endtask

    task automatic test_wormhole_hold();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, i >= 3, 1'b1);
            checks++; if ({grant_ring, local_ready, pkt_done} !== {2'b10, i == 8}) $display("FAIL hold c%0d got=%b exp=%b", i, {grant_ring, local_ready, pkt_done}, {2'b10, i == 8}); else passes++;
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if ({grant_local, local_ready, out_valid, out_head} !== 4'b1111) $display("FAIL hold_nobubble got=%b exp=1111", {grant_local, local_ready, out_valid, out_head}); else passes++;
        tick();
        for (int i = 1; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            checks++; if (pkt_done !== (i == 8)) $display("FAIL hold_local_done c%0d got=%b exp=%b", i, pkt_done, i == 8); else passes++;
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        logic [FLIT_W-1:0] got[$];
        int start;
        start = ring_seq;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 1'b0, (i % 2) == 0);
            checks++; if (ring_ready !== ((i % 2) == 0)) $display("FAIL bp_ready c%0d got=%b exp=%b", i, ring_ready, (i % 2) == 0); else passes++;
            checks++; if (pkt_done !== (i == 16)) $display("FAIL bp_done c%0d got=%b exp=%b", i, pkt_done, i == 16); else passes++;
            if (ring_valid && ring_ready) got.push_back(out_flit);
            tick();
        end
        checks++;
        if (got.size() !== FLITS) $display("FAIL bp_count got=%0d exp=%0d", got.size(), FLITS);
        else begin
            passes++;
            for (int k = 0; k < int'(FLITS); k++) begin
                checks++; if (got[k] !== rflit(start + k)) $display("FAIL bp_flit k%0d got=%h exp=%h", k, got[k], rflit(start + k)); else passes++;
            end
        end
    endtask

    task automatic test_owner_stall();
        logic stall;
        for (int i = 0; i < 12; i++) begin
            stall = (i >= 5) && (i <= 7);
            drive(1'b1, !stall, i >= 1, 1'b1);
            checks++; if ({grant_ring, local_ready} !== 2'b10) $display("FAIL stall_grant c%0d got=%b exp=10", i, {grant_ring, local_ready}); else passes++;
            checks++; if ({out_valid, pkt_done} !== {!stall, i == 11}) $display("FAIL stall_valid c%0d got=%b exp=%b", i, {out_valid, pkt_done}, {!stall, i == 11}); else passes++;
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_starvation();
        int winners[$];
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 10 * int'(FLITS); c++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1);
            if (out_head && out_valid && out_ready) winners.push_back(grant_local ? 2 : 1);
            tick();
        end
        checks++;
        if (winners.size() != 10) $display("FAIL starve_count got=%0d exp=10", winners.size());
        else begin
            passes++;
            for (int k = 0; k < 10; k++) begin
                int exp_w;
                exp_w = (STARVE_ON && (k % 5) == 4) ? 2 : 1;
                checks++; if (winners[k] != exp_w) $display("FAIL starve_seq k%0d got=%0d exp=%0d", k, winners[k], exp_w); else passes++;
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset_mid_packet();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if ({out_head, pkt_done, grant_local} !== 3'b101) $display("FAIL rst_mid_during got=%b exp=101", {out_head, pkt_done, grant_local}); else passes++;
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if ({out_head, pkt_done, local_ready} !== 3'b101) $display("FAIL rst_mid_after got=%b exp=101", {out_head, pkt_done, local_ready}); else passes++;
        tick();
        for (int i = 1; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            checks++; if ({out_head, pkt_done} !== {1'b0, i == 8}) $display("FAIL rst_mid_pkt c%0d got=%b exp=%b", i, {out_head, pkt_done}, {1'b0, i == 8}); else passes++;
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        logic [6:0] got_v, exp_v;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 400) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0);
            got_v = {grant_ring, grant_local, out_valid, ring_ready, local_ready, out_head, pkt_done};
            exp_v = {e_gr, e_gl, e_valid, e_rr, e_lr, e_head, e_done};
            checks++; if (got_v !== exp_v) $display("FAIL rand_ctl c%0d got=%b exp=%b", c, got_v, exp_v); else passes++;
            if (e_valid) begin
                checks++; if (out_flit !== e_flit) $display("FAIL rand_flit c%0d got=%h exp=%h", c, out_flit, e_flit); else passes++;
            end
            tick();
        end
    endtask

    initial begin
        rst_l       = 1'b0;
        ring_valid  = 1'b0;
        local_valid = 1'b0;
        out_ready   = 1'b0;
        ring_flit   = '0;
        local_flit  = '0;
        @(negedge clk);
        test_reset();
        test_single_local();
        test_wormhole_hold();
        test_backpressure();
        test_owner_stall();
        test_starvation();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ring_port_arbiter.md
# ring_port_arbiter

Wormhole output-port arbiter for one ring node. It shares the node's single outbound link between two flit sources: through-traffic from the upstream ring neighbour, and local injection from the core's packet-to-flit serializer. A source is granted at a packet boundary and holds the link for all flits of that packet, so flits of different packets never interleave on a link. One instance sits between each node's input mux and its outbound link register.

## Interface
- FLIT_W, 64, flit width in bits
- FLITS, 9, flits per packet (≥2); the first flit is the head
- STARVE_MAX, 4, maximum consecutive ring packets granted while local is waiting (≥1)

- clk  in  1  clock
- rst_l  in  1  reset: one clock, synchronous, active-low
- ring_valid  in  1  upstream flit available
- ring_flit  in  FLIT_W  upstream flit
- ring_ready  out  1  upstream flit accepted this cycle when ring_valid is high
- local_valid  in  1  serializer flit available
- local_flit  in  FLIT_W  serializer flit
- local_ready  out  1  serializer flit accepted this cycle when local_valid is high
- out_valid  out  1  flit presented on the outbound link
- out_flit  out  FLIT_W  outbound flit
- out_ready  in  1  downstream can take a flit
- out_head  out  1  out_flit is the head flit of a packet
- grant_ring  out  1  ring owns the link (one-hot with grant_local)
- grant_local  out  1  local owns the link
- pkt_done  out  1  one-cycle pulse: last flit transferred this cycle

## Operation
- A flit transfers when out_valid && out_ready. The datapath is combinational: out_flit is the owner's flit, and out_valid is the owner's valid.
- The non-owner's ready is always 0. The owner's ready equals out_ready.
- FSM states: IDLE, RING, LOCAL. The flit counter fcnt runs 0..FLITS-1.
- **IDLE:**
  - The combinational grant goes to ring if only ring_valid is high.
  - It goes to local if only local_valid is high.
  - If both are high, apply the priority rule below.
  - The grant outputs reflect the winner in the same cycle.
  - out_head=1.
  - On head transfer: set fcnt=1 and go to RING/LOCAL.
  - With no head transfer, stay in IDLE and re-arbitrate next cycle. The grant is not latched.
- **RING/LOCAL:**
  - The grant is held.
  - Each transfer increments fcnt.
  - A transfer when fcnt==FLITS-1 pulses pkt_done, clears fcnt, and returns to IDLE.
  - The next packet may be granted in the following cycle (zero-bubble back-to-back).
- If the owner drops valid mid-packet, the link idles (out_valid=0). The grant is still held, and the other source is not granted.
- Priority when both are valid in IDLE: ring wins, unless the starvation rule applies (see Configuration).
- Starvation counter scnt, width $clog2(STARVE_MAX+1):
  - Increments on a ring head transfer while local_valid=1.
  - Clears on a local head transfer.
  - Saturates at STARVE_MAX.
  - When scnt==STARVE_MAX, local wins the next contested IDLE arbitration.
- Head flits are identified only by position (fcnt==0). Flit contents are not inspected.

## Timing
- Reset (rst_l=0 at posedge) sets: state=IDLE, fcnt=0, scnt=0.
- Output values follow from those register values:
  - grant_*, ready, out_valid and out_flit are combinational. During reset they reflect IDLE arbitration of the current inputs.
  - pkt_done=0 and out_head=1.
- Reset mid-packet abandons the packet. The next transfer is treated as a head. Upstream sources must also be reset.
- Latency from input to outbound is 0 cycles. A packet occupies the link for at least FLITS cycles.
- Simultaneous last-flit transfer and new valids: they are arbitrated in the next cycle (IDLE).
- out_ready low: no state changes. Counters advance only on a transfer.

## Configuration
- RING_ARB_STARVE_EN defined: the scnt starvation rule above is active. Local is guaranteed a grant after at most STARVE_MAX contested ring packets.
- RING_ARB_STARVE_EN undefined:
  - scnt is not implemented.
  - Ring has strict priority.
  - Local is granted only when ring_valid=0 in IDLE.

## Test plan
- **Single local packet:** local_valid=1 with out_ready=1 for 9 cycles.
  - grant_local is held for 9 cycles.
  - out_head is high only in cycle 0.
  - pkt_done pulses in cycle 8.
  - State is IDLE in cycle 9.
- **Wormhole hold:** ring packet in progress, local_valid asserted at flit 3.
  - local_ready stays 0 until ring's pkt_done.
  - The local head transfers in the next cycle with no bubble.
- **Backpressure:** out_ready toggled 1,0,1,0 during a ring packet.
  - fcnt advances only on transfers.
  - The packet completes after exactly 9 transfers.
  - No flit is duplicated or dropped (scoreboard compare).
- **Owner stall:** ring_valid drops at flit 5 for 3 cycles while local_valid=1.
  - out_valid=0 for those 3 cycles.
  - grant_ring is held.
  - local_ready=0 throughout.
- **Starvation (STARVE_MAX=4, macro defined):** both sources continuously valid.
  - Grant sequence is ring×4, local, ring×4, local.
  - Without the macro, the sequence is ring only.
- **Reset mid-packet:** rst_l=0 at flit 4 of a local packet.
  - Next cycle: state=IDLE, pkt_done=0, scnt=0.
  - The next transfer asserts out_head=1.
